// File: rtl/cnn_rx_pkg.sv
// -----------------------------------------------------------------------------
// cnn_rx_pkg
// Shared definitions for the CNN frame receiver:
//   - rx_state_t   : receiver FSM states (IDLE, RECV, LAUNCH)
//   - ERR_*        : frame error codes, carried in error_code[15:0]
//   - first_error(): sticky "first error wins" merge helper
// -----------------------------------------------------------------------------
package cnn_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    LAUNCH = 2'd2
  } rx_state_t;

  localparam logic [15:0] ERR_NONE      = 16'h0000;
  localparam logic [15:0] ERR_OVERFLOW  = 16'h0003;
  localparam logic [15:0] ERR_UNDERFLOW = 16'h0004;
  localparam logic [15:0] ERR_RESTART   = 16'h0005;
  localparam logic [15:0] ERR_NO_FRAME  = 16'h0006;

  // Keep an already latched error; only a clean code may take a new one.
  function automatic logic [15:0] first_error(input logic [15:0] cur,
                                              input logic [15:0] cand);
    return (cur == ERR_NONE) ? cand : cur;
  endfunction

endpackage

// File: rtl/cnn_pixel_packer.sv
// -----------------------------------------------------------------------------
// cnn_pixel_packer
// Packs accepted 8-bit pixels four at a time into 32-bit frame-buffer words.
// Byte lane 0 holds the earliest pixel of each word. The write strobe is
// registered, so it appears one cycle after the pixel that fills lane 3.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clear         : start of a new frame; restarts lane and word address
//   accept        : pixel_data is an accepted pixel this cycle
//   pixel_data    : pixel value
//   buf_wr_en     : one-cycle frame-buffer write strobe
//   buf_wr_addr   : word address of the write
//   buf_wr_data   : packed word
// -----------------------------------------------------------------------------
module cnn_pixel_packer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        pixel_data,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [31:0]       buf_wr_data
);

  logic [1:0]        lane_reg;
  logic [ADDR_W-1:0] word_addr_reg;
  logic [31:0]       pack_reg;
  logic [31:0]       pack_next;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [31:0]       wr_data_reg;

  // The completed word is taken from pack_next so the lane-3 byte
  // arriving this cycle is already in place when the write is registered.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign pack_next[gi*8 +: 8] = (accept && (lane_reg == 2'(gi))) ?
                                    pixel_data : pack_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_reg      <= 2'd0;
      word_addr_reg <= '0;
      pack_reg      <= 32'd0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= 32'd0;
    end else begin
      wr_en_reg <= 1'b0;
      if (clear) begin
        lane_reg      <= 2'd0;
        word_addr_reg <= '0;
        pack_reg      <= 32'd0;
      end else if (accept) begin
        pack_reg <= pack_next;
        lane_reg <= lane_reg + 2'd1;
        if (lane_reg == 2'd3) begin
          wr_en_reg     <= 1'b1;
          wr_addr_reg   <= word_addr_reg;
          wr_data_reg   <= pack_next;
          word_addr_reg <= word_addr_reg + 1'b1;
        end
      end
    end
  end

  assign buf_wr_en   = wr_en_reg;
  assign buf_wr_addr = wr_addr_reg;
  assign buf_wr_data = wr_data_reg;

endmodule

// File: rtl/cnn_frame_receiver.sv
// -----------------------------------------------------------------------------
// cnn_frame_receiver
// Receives a frame_start / pixel_valid / frame_complete pixel stream, packs
// pixels into the CNN input frame buffer, checks frame integrity and issues a
// single cnn_start pulse once the CNN core is idle.
//
// Build option: define CNN_RX_CHECKSUM_EN to keep a 16-bit running sum of
// accepted pixels (cleared on frame_start) on error_code[31:16]. Without it
// error_code[31:16] is zero.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   frame_start     : one-cycle pulse, frame begins
//   pixel_valid     : one-cycle pulse, pixel_data valid
//   pixel_data      : pixel value
//   frame_complete  : one-cycle pulse, frame ends
//   cnn_busy        : CNN core busy
//   buf_wr_en       : frame-buffer write strobe
//   buf_wr_addr     : frame-buffer word address
//   buf_wr_data     : packed pixels, byte0 = earliest pixel
//   cnn_start       : one-cycle start pulse to the CNN
//   rx_busy         : high in RECV or LAUNCH
//   pixel_count     : pixels accepted in current/last frame
//   frame_ok_count  : frames launched since reset
//   error_code      : first error of current/last frame
// -----------------------------------------------------------------------------
module cnn_frame_receiver
  import cnn_rx_pkg::*;
#(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pixel_valid,
  input  logic [7:0]        pixel_data,
  input  logic              frame_complete,
  input  logic              cnn_busy,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [31:0]       buf_wr_data,
  output logic              cnn_start,
  output logic              rx_busy,
  output logic [31:0]       pixel_count,
  output logic [31:0]       frame_ok_count,
  output logic [31:0]       error_code
);

  localparam logic [31:0] N_PIX = 32'(IMG_WIDTH * IMG_HEIGHT);

  rx_state_t   state_reg;
  logic [31:0] pixel_count_reg;
  logic [31:0] frame_ok_count_reg;
  logic [15:0] err_reg;
  logic        cnn_start_reg;

  logic        in_recv;
  logic        start_take;
  logic        count_full;
  logic        accept;
  logic        overflow_hit;
  logic [31:0] count_upd;
  logic [15:0] err_upd;

  // frame_start dominates any pixel or completion in the same cycle, so a
  // pixel arriving with frame_start is dropped. LAUNCH ignores the stream.
  always_comb begin
    in_recv      = (state_reg == RECV);
    start_take   = frame_start && (state_reg != LAUNCH);
    count_full   = (pixel_count_reg >= N_PIX);
    accept       = in_recv && !frame_start && pixel_valid && !count_full;
    overflow_hit = in_recv && !frame_start && pixel_valid && count_full;
    // Count and error as they stand after this cycle's pixel; the
    // completion check must see the pixel that arrives alongside it.
    count_upd    = accept ? (pixel_count_reg + 32'd1) : pixel_count_reg;
    err_upd      = overflow_hit ? first_error(err_reg, ERR_OVERFLOW) : err_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      pixel_count_reg    <= 32'd0;
      frame_ok_count_reg <= 32'd0;
      err_reg            <= ERR_NONE;
      cnn_start_reg      <= 1'b0;
    end else begin
      cnn_start_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (frame_start) begin
            state_reg       <= RECV;
            pixel_count_reg <= 32'd0;
            err_reg         <= ERR_NONE;
          end else if (pixel_valid || frame_complete) begin
            err_reg <= first_error(err_reg, ERR_NO_FRAME);
          end
        end

        RECV: begin
          if (frame_start) begin
            // Restart inside a frame: counters restart, but the error
            // stays latched so the restarted frame can never launch.
            pixel_count_reg <= 32'd0;
            err_reg         <= first_error(err_reg, ERR_RESTART);
          end else begin
            pixel_count_reg <= count_upd;
            if (frame_complete) begin
              if ((count_upd == N_PIX) && (err_upd == ERR_NONE)) begin
                state_reg <= LAUNCH;
                err_reg   <= err_upd;
              end else begin
                state_reg <= IDLE;
                err_reg   <= (count_upd < N_PIX) ?
                             first_error(err_upd, ERR_UNDERFLOW) : err_upd;
              end
            end else begin
              err_reg <= err_upd;
            end
          end
        end

        LAUNCH: begin
          if (!cnn_busy) begin
            cnn_start_reg      <= 1'b1;
            frame_ok_count_reg <= frame_ok_count_reg + 32'd1;
            state_reg          <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef CNN_RX_CHECKSUM_EN
  logic [15:0] sum_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg <= 16'd0;
    end else if (start_take) begin
      sum_reg <= 16'd0;
    end else if (accept) begin
      sum_reg <= sum_reg + {8'd0, pixel_data};
    end
  end

  assign error_code = {sum_reg, err_reg};
`else
  assign error_code = {16'd0, err_reg};
`endif

  cnn_pixel_packer #(
    .ADDR_W (ADDR_W)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_take),
    .accept      (accept),
    .pixel_data  (pixel_data),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .buf_wr_data (buf_wr_data)
  );

  assign cnn_start      = cnn_start_reg;
  assign rx_busy        = (state_reg != IDLE);
  assign pixel_count    = pixel_count_reg;
  assign frame_ok_count = frame_ok_count_reg;

endmodule

// File: tb/tb_cnn_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_cnn_frame_receiver
// Self-checking bench for cnn_frame_receiver with a 4x4 image. Expected
// buffer words, error codes, counts and start timing are computed per frame
// from the list of pixels sent.
// -----------------------------------------------------------------------------
module tb_cnn_frame_receiver;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 4;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          pixel_valid;
  logic [7:0]    pixel_data;
  logic          frame_complete;
  logic          cnn_busy;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic [31:0]   buf_wr_data;
  logic          cnn_start;
  logic          rx_busy;
  logic [31:0]   pixel_count;
  logic [31:0]   frame_ok_count;
  logic [31:0]   error_code;

  cnn_frame_receiver #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .ADDR_W     (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .pixel_valid    (pixel_valid),
    .pixel_data     (pixel_data),
    .frame_complete (frame_complete),
    .cnn_busy       (cnn_busy),
    .buf_wr_en      (buf_wr_en),
    .buf_wr_addr    (buf_wr_addr),
    .buf_wr_data    (buf_wr_data),
    .cnn_start      (cnn_start),
    .rx_busy        (rx_busy),
    .pixel_count    (pixel_count),
    .frame_ok_count (frame_ok_count),
    .error_code     (error_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int ncyc  = 0;
  int fc_cyc = 0;
  int exp_ok = 0;

  logic [AW+31:0] got_wr[$];
  int             got_wr_cyc[$];
  int             got_start[$];
  logic [AW+31:0] exp_wr[$];
  logic [7:0]     seg[$];

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (frame_complete) fc_cyc = ncyc;
    if (buf_wr_en) begin
      got_wr.push_back({buf_wr_addr, buf_wr_data});
      got_wr_cyc.push_back(ncyc);
    end
    if (cnn_start) got_start.push_back(ncyc);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic fs, input logic pv, input logic [7:0] pd, input logic fc);
    frame_start    = fs;
    pixel_valid    = pv;
    pixel_data     = pd;
    frame_complete = fc;
    @(posedge clk);
    #1;
    frame_start    = 1'b0;
    pixel_valid    = 1'b0;
    frame_complete = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic clear_obs();
    got_wr.delete();
    got_wr_cyc.delete();
    got_start.delete();
    exp_wr.delete();
  endtask

  // Every complete group of four accepted pixels becomes one word.
  task automatic add_words();
    for (int w = 0; w < seg.size() / 4; w++)
      exp_wr.push_back({AW'(w), seg[4*w+3], seg[4*w+2], seg[4*w+1], seg[4*w]});
  endtask

  function automatic logic [31:0] exp_code(input logic [15:0] e);
`ifdef CNN_RX_CHECKSUM_EN
    logic [15:0] s;
    s = 16'd0;
    foreach (seg[i]) s = s + {8'd0, seg[i]};
    return {s, e};
`else
    return {16'd0, e};
`endif
  endfunction

  task automatic send_pixels(input int n, input bit fixed, input bit merge_fc,
                             input int busy, input bit gaps);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = fixed ? 8'(i) : 8'($urandom);
      if (gaps) idle($urandom_range(0, 2));
      if (seg.size() < N) seg.push_back(d);
      if (merge_fc && i == n - 1) begin
        cnn_busy = (busy > 0);
        step(1'b0, 1'b1, d, 1'b1);
      end else begin
        step(1'b0, 1'b1, d, 1'b0);
      end
    end
  endtask

  task automatic check_frame(input logic [15:0] err, input bit launch,
                             input int cnt, input int busy);
    int m;
    check("wr_count", 64'(got_wr.size()), 64'(exp_wr.size()));
    m = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
    for (int i = 0; i < m; i++) check("wr_word", 64'(got_wr[i]), 64'(exp_wr[i]));
    check("start_count", 64'(got_start.size()), launch ? 64'd1 : 64'd0);
    if (launch && got_start.size() > 0) begin
      check("start_cycle", 64'(got_start[0]), 64'(fc_cyc + 2 + busy));
      if (got_wr_cyc.size() > 0)
        check("wr_before_start", 64'(got_wr_cyc[got_wr_cyc.size()-1] < got_start[0]), 64'd1);
    end
    check("pixel_count", 64'(pixel_count), 64'(cnt));
    check("error_code", 64'(error_code), 64'(exp_code(err)));
    check("frame_ok_count", 64'(frame_ok_count), 64'(exp_ok));
    check("rx_busy_end", 64'(rx_busy), 64'd0);
  endtask

  task automatic run_frame(input int npix, input bit fixed, input bit merge,
                           input int busy, input bit gaps);
    logic [15:0] err;
    bit          launch;
    clear_obs();
    seg.delete();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    send_pixels(npix, fixed, merge, busy, gaps);
    if (!merge) begin
      if (gaps) idle($urandom_range(0, 2));
      cnn_busy = (busy > 0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    idle(busy);
    cnn_busy = 1'b0;
    idle(4);
    add_words();
    err    = (npix > N) ? 16'h3 : (npix < N) ? 16'h4 : 16'h0;
    launch = (npix == N);
    if (launch) exp_ok++;
    check_frame(err, launch, (npix > N) ? N : npix, busy);
    $display("frame: npix=%0d merge=%0d busy=%0d writes=%0d starts=%0d err=0x%0h",
             npix, merge, busy, got_wr.size(), got_start.size(), error_code);
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0; pixel_valid = 1'b0; pixel_data = 8'h00;
    frame_complete = 1'b0; cnn_busy = 1'b0;
    idle(3);
    check("rst_wr_en", 64'(buf_wr_en), 64'd0);
    check("rst_start", 64'(cnn_start), 64'd0);
    check("rst_busy", 64'(rx_busy), 64'd0);
    check("rst_count", 64'(pixel_count), 64'd0);
    check("rst_ok", 64'(frame_ok_count), 64'd0);
    check("rst_err", 64'(error_code), 64'd0);
    $display("reset: outputs checked");
    rst = 1'b0;
    idle(2);

    // Nominal frame with pixels 0x00..0x0F
    run_frame(N, 1'b1, 1'b0, 0, 1'b0);
    if (got_wr.size() == 4) begin
      check("nominal_word0", 64'(got_wr[0]), 64'({4'd0, 32'h03020100}));
      check("nominal_word3", 64'(got_wr[3]), 64'({4'd3, 32'h0F0E0D0C}));
    end

    // Stray pixel while idle
    clear_obs();
    step(1'b0, 1'b1, 8'h55, 1'b0);
    idle(3);
    check("idle_err", 64'(error_code), 64'(exp_code(16'h6)));
    check("idle_writes", 64'(got_wr.size()), 64'd0);
    check("idle_count", 64'(pixel_count), 64'(N));
    $display("idle pixel: err=0x%0h", error_code);

    // Busy hold, last pixel coincides with frame_complete
    run_frame(N, 1'b0, 1'b1, 10, 1'b1);
    // Underflow and overflow
    run_frame(N - 2, 1'b0, 1'b0, 0, 1'b1);
    if (got_wr.size() > 0)
      check("underflow_last_addr", 64'(got_wr[got_wr.size()-1][AW+31:32]), 64'd2);
    run_frame(N + 1, 1'b0, 1'b0, 0, 1'b1);

    // Restart inside a frame, then a full frame that must stay blocked
    clear_obs();
    seg.delete();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    send_pixels(5, 1'b0, 1'b0, 0, 1'b0);
    add_words();
    seg.delete();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    idle(1);
    check("restart_err", 64'(error_code), 64'(exp_code(16'h5)));
    check("restart_count", 64'(pixel_count), 64'd0);
    check("restart_busy", 64'(rx_busy), 64'd1);
    send_pixels(N, 1'b0, 1'b1, 0, 1'b1);
    idle(4);
    add_words();
    check_frame(16'h5, 1'b0, N, 0);
    $display("restart: writes=%0d starts=%0d err=0x%0h", got_wr.size(), got_start.size(), error_code);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      int np;
      np = ($urandom_range(0, 1) == 1) ? N : (N - 2 + int'($urandom_range(0, 4)));
      run_frame(np, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b1);
    end

    // Reset in the middle of a frame
    clear_obs();
    seg.delete();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    send_pixels(9, 1'b0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    clear_obs();
    idle(1);
    check("mid_rst_wr_en", 64'(buf_wr_en), 64'd0);
    check("mid_rst_addr", 64'(buf_wr_addr), 64'd0);
    check("mid_rst_data", 64'(buf_wr_data), 64'd0);
    check("mid_rst_busy", 64'(rx_busy), 64'd0);
    check("mid_rst_count", 64'(pixel_count), 64'd0);
    check("mid_rst_ok", 64'(frame_ok_count), 64'd0);
    check("mid_rst_err", 64'(error_code), 64'd0);
    idle(1);
    rst = 1'b0;
    idle(6);
    check("mid_rst_no_write", 64'(got_wr.size()), 64'd0);
    check("mid_rst_no_start", 64'(got_start.size()), 64'd0);
    $display("reset mid-frame: outputs checked");
    exp_ok = 0;
    seg.delete();
    run_frame(N, 1'b0, 1'b0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cnn_frame_receiver.md
Name: cnn_frame_receiver

Overview:
CNN-side receiver for the MicroBlaze-driven pixel stream of frame_start, pixel_valid/pixel_data and frame_complete pulses.
- Packs pixels four at a time into 32-bit words and writes them into the CNN input frame buffer.
- Checks frame integrity, then issues a single cnn_start pulse once the CNN is idle.
- Sits between the control-logic block and the CNN core.

Parameters:
IMG_WIDTH, 32, pixels per row
IMG_HEIGHT, 32, rows per frame
ADDR_W, 8, buffer word-address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT/4

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
frame_start  in  1  one-cycle pulse, frame begins
pixel_valid  in  1  one-cycle pulse, pixel_data valid
pixel_data  in  8  pixel value
frame_complete  in  1  one-cycle pulse, frame ends
cnn_busy  in  1  CNN core busy
buf_wr_en  out  1  frame-buffer write strobe
buf_wr_addr  out  ADDR_W  word address
buf_wr_data  out  32  packed pixels, byte0 = earliest pixel
cnn_start  out  1  one-cycle start pulse to CNN
rx_busy  out  1  high in RECV or LAUNCH
pixel_count  out  32  pixels accepted in current/last frame
frame_ok_count  out  32  frames launched since reset
error_code  out  32  first error of current/last frame

Behaviour:
- One clock; reset is synchronous and active-high.
- On rst: all outputs 0, FSM to IDLE, pack register cleared. A rst asserted mid-frame discards the frame; no write and no start follow.
- N = IMG_WIDTH*IMG_HEIGHT.
- Error codes (sticky, first error wins, cleared on frame_start):
  - NONE = 0x0
  - OVERFLOW = 0x3: pixel beyond N
  - UNDERFLOW = 0x4: frame_complete with count < N
  - RESTART = 0x5: frame_start while in RECV
  - NO_FRAME = 0x6: pixel_valid or frame_complete while in IDLE
- FSM states:
  - IDLE:
    - frame_start -> RECV; clear pixel_count, pack register and error_code.
    - pixel_valid or frame_complete -> set NO_FRAME; stay in IDLE; no write.
  - RECV, on pixel_valid:
    - If pixel_count < N: store the byte in lane pixel_count[1:0], then increment pixel_count.
    - When lane 3 is filled, pulse buf_wr_en exactly one cycle later with buf_wr_addr = (pixel_count before increment) >> 2.
    - If pixel_count == N: set OVERFLOW; drop the pixel; no write.
  - RECV, on frame_complete:
    - Go to LAUNCH if pixel_count == N and error_code == NONE.
    - Otherwise set UNDERFLOW if the count is short, then go to IDLE.
    - A partial word is never written.
  - RECV, on frame_start: set RESTART (unless an error is already latched), clear counters and pack register, stay in RECV.
  - LAUNCH:
    - While cnn_busy = 1: hold.
    - When cnn_busy = 0: pulse cnn_start one cycle, increment frame_ok_count, go to IDLE.
- Simultaneous events:
  - pixel_valid and frame_complete in the same cycle: the pixel is accepted first, and the completion check uses the updated count.
  - frame_start together with frame_complete in RECV: frame_start wins.
- Latency:
  - Fourth pixel at cycle T -> write at T+1.
  - frame_complete at T -> LAUNCH at T+1 -> cnn_start earliest at T+2.
  - The final write always precedes cnn_start.
- Counters wrap modulo 2^32; buf_wr_addr never exceeds N/4-1.

Optional Feature:
- Macro: CNN_RX_CHECKSUM_EN.
- When defined:
  - A 16-bit running sum (mod 2^16) of accepted pixels is kept; it is cleared on frame_start.
  - The sum is exposed on error_code[31:16]. Error codes then occupy bits [15:0] only.
- When undefined: no checksum logic; error_code[31:16] = 0.

Decomposition:
- Package cnn_rx_pkg holds the error-code constants and the FSM state enum (IDLE, RECV, LAUNCH).
- Sub-module cnn_pixel_packer holds the lane counter, 32-bit pack register and write strobe/address generation.
- The top level holds the FSM, error logic and start handshake.

Test Plan:
- Nominal frame, IMG_WIDTH=IMG_HEIGHT=4: frame_start, pixels 0x00..0x0F, frame_complete, cnn_busy=0 ->
  - writes addr0=0x03020100 … addr3=0x0F0E0D0C;
  - one cnn_start 2 cycles after frame_complete;
  - frame_ok_count=1, error_code=0.
- Busy hold: same frame with cnn_busy=1 for 10 cycles after frame_complete -> no cnn_start until the cycle after cnn_busy drops; exactly one pulse.
- Underflow: 14 pixels, then frame_complete -> error_code=0x4, no cnn_start, last write at addr2, pixel_count=14.
- Overflow: 17 pixels, then frame_complete -> 4 writes only, error_code=0x3, no cnn_start.
- Restart and idle misuse:
  - pixel_valid in IDLE -> error_code=0x6.
  - frame_start, 5 pixels, frame_start -> error_code=0x5, pixel_count=0.
  - 16 more pixels plus frame_complete -> launch still blocked (sticky error).
- Reset mid-frame: rst after 9 pixels -> all outputs 0; no cnn_start; next clean frame launches normally with frame_ok_count=1.
